// File: rtl/wavelet_level_sequencer.sv
// wavelet_level_sequencer: capture controller issuing per-level decimated sample strobes.
module wavelet_level_sequencer #(
  parameter int NUM_LEVELS   = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  capture_len,
  input  logic                  adc_data_in_valid,
  output logic [NUM_LEVELS-1:0] level_en,
  output logic [NUM_LEVELS-1:0] level_phase,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sample_count
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [NUM_LEVELS-1:0] r_dec;
  logic [DW-1:0]         r_drain;
  logic [NUM_LEVELS-1:0] r_en;
  logic [NUM_LEVELS-1:0] r_ph;
  logic                  r_done;
  logic [NUM_LEVELS-1:0] w_en;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_acc;
  logic                  w_last;
  // level k fires when the low k bits of the decimation counter are all ones
  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_en
    if (i == 0) begin : g_full
      assign w_en[i] = 1'b1;
    end else begin : g_dec
      assign w_en[i] = &r_dec[i-1:0];
    end
  end
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_acc        = (r_state == S_RUN) && adc_data_in_valid && !stop;
  assign w_last       = w_acc && (r_len != '0) && (w_cnt_inc == r_len);
  assign level_en     = r_en;
  assign level_phase  = r_ph;
  assign busy         = r_state != S_IDLE;
  assign done         = r_done;
  assign sample_count = r_cnt;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dec   <= '0;
      r_drain <= '0;
      r_en    <= '0;
      r_ph    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_en   <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RUN;
          r_len   <= capture_len;
          r_cnt   <= '0;
          r_dec   <= '0;
        end
        S_RUN: begin
          if (w_acc) begin
            r_en  <= w_en;
            r_ph  <= r_dec;
            r_dec <= r_dec + 1'b1;
            r_cnt <= w_cnt_inc;
          end
          if (stop || w_last) begin
            r_state <= S_DRAIN;
            r_drain <= DW'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: if (r_drain == '0) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_drain <= r_drain - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
